// File: rtl/vector_cmd_ctrl.sv
// rtl/vector_cmd_ctrl.sv - command/control FSM sequencing vector ops, result load and byte-wise UART transmission
module vector_cmd_ctrl #(
   parameter int NUM_ELEMENTOS    = 1024,
   parameter int BYTES_PER_RESULT = 2,
   parameter int LAT_READ         = 1,
   parameter int LAT_SUM          = 1,
   parameter int LAT_AVG          = 2,
   parameter int LAT_TREE         = $clog2(NUM_ELEMENTOS) + 2,
   parameter int LAT_EUC          = $clog2(NUM_ELEMENTOS) + 18,
   localparam int BSW = (BYTES_PER_RESULT > 1) ? $clog2(BYTES_PER_RESULT) : 1
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_command_ready,
   input  logic [7:0]     i_command,
   input  logic           i_write_done,
   input  logic           i_tx_sent,
   output logic           o_begin_write,
   output logic           o_begin_transmission,
   output logic [BSW-1:0] o_byte_sel,
   output logic           o_read_mem_sel,
   output logic           o_load_mem,
   output logic           o_shift_mem,
   output logic [5:0]     o_enables,
   output logic           o_busy,
   output logic           o_cmd_error
);

   // element counter is one bit wider than needed so it never wraps
   localparam int CW = $clog2(NUM_ELEMENTOS) + 1;
   // timer sized from the latency sum, which bounds every single latency
   localparam int TW = $clog2(LAT_READ + LAT_SUM + LAT_AVG + LAT_TREE + LAT_EUC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_COMPUTE, S_STORE, S_SEND, S_WAIT_TX, S_SHIFT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_cmd;
   logic [TW-1:0]   r_timer;
   logic [BSW-1:0]  r_byte_sel;
   logic [CW-1:0]   r_elem;
   logic            r_cmd_error;
   logic [2:0]      w_ones;
   logic            w_one_hot;
   logic [TW-1:0]   w_lat_m1;
   logic            w_last_byte;
   logic            w_more;

   // population count of the op field of the incoming command
   always_comb begin
      w_ones = '0;
      for (int k = 0; k < 7; k++) begin
         w_ones = w_ones + {2'b00, i_command[k]};
      end
   end

   assign w_one_hot   = (w_ones == 3'd1);
   assign w_last_byte = (r_byte_sel == BSW'(BYTES_PER_RESULT - 1));
   // only READ/SUM/AVG produce a full vector; scalar ops stop after one element
   assign w_more      = (|r_cmd[3:1]) && (r_elem < CW'(NUM_ELEMENTOS - 1));

   // compute latency (minus one) of the latched op
   always_comb begin
      w_lat_m1 = TW'(LAT_READ - 1);
      if (r_cmd[2])      w_lat_m1 = TW'(LAT_SUM - 1);
      else if (r_cmd[3]) w_lat_m1 = TW'(LAT_AVG - 1);
      else if (r_cmd[4]) w_lat_m1 = TW'(LAT_EUC - 1);
      else if (r_cmd[5]) w_lat_m1 = TW'(LAT_TREE - 1);
      else if (r_cmd[6]) w_lat_m1 = TW'(LAT_TREE - 1);
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_command_ready && w_one_hot)
                       w_state_nxt = i_command[0] ? S_WRITE : S_COMPUTE;
         S_WRITE:   if (i_write_done) w_state_nxt = S_IDLE;
         S_COMPUTE: if (r_timer == w_lat_m1) w_state_nxt = S_STORE;
         S_STORE:   w_state_nxt = S_SEND;
         S_SEND:    w_state_nxt = S_WAIT_TX;
         S_WAIT_TX: if (i_tx_sent) begin
                       if (!w_last_byte) w_state_nxt = S_SEND;
                       else if (w_more)  w_state_nxt = S_SHIFT;
                       else              w_state_nxt = S_IDLE;
                    end
         S_SHIFT:   w_state_nxt = S_SEND;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // command latch, error flag, timer, byte and element counters
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cmd       <= '0;
         r_timer     <= '0;
         r_byte_sel  <= '0;
         r_elem      <= '0;
         r_cmd_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_command_ready) begin
                  if (w_one_hot) begin
                     r_cmd       <= i_command;
                     r_cmd_error <= 1'b0;
                     r_timer     <= '0;
                     r_byte_sel  <= '0;
                     r_elem      <= '0;
                  end else begin
                     r_cmd_error <= 1'b1;
                  end
               end
            S_COMPUTE: r_timer <= r_timer + 1'b1;
            S_WAIT_TX: if (i_tx_sent) begin
                  if (!w_last_byte)  r_byte_sel <= r_byte_sel + 1'b1;
                  else if (!w_more)  r_byte_sel <= '0;
               end
            S_SHIFT: begin
               r_elem     <= r_elem + 1'b1;
               r_byte_sel <= '0;
            end
            default: ;
         endcase
      end
   end

   // decoded outputs
   always_comb begin
      o_begin_write        = (r_state == S_WRITE);
      o_begin_transmission = (r_state == S_SEND);
      o_load_mem           = (r_state == S_STORE);
      o_shift_mem          = (r_state == S_SHIFT);
      o_busy               = (r_state != S_IDLE);
      o_enables            = 6'b0;
      if (r_state != S_IDLE && r_state != S_WRITE) o_enables = r_cmd[6:1];
      o_read_mem_sel       = r_cmd[1] && (r_state != S_IDLE) && !r_cmd[7];
   end

   assign o_byte_sel  = r_byte_sel;
   assign o_cmd_error = r_cmd_error;

endmodule

// File: tb/tb_vector_cmd_ctrl.sv
// tb/tb_vector_cmd_ctrl.sv - scoreboard bench for vector_cmd_ctrl with randomized commands
module tb_vector_cmd_ctrl;

   localparam int N   = 4;
   localparam int BPR = 2;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_command_ready = 1'b0;
   logic [7:0] i_command = 8'h00;
   logic       i_write_done = 1'b0;
   logic       i_tx_sent = 1'b0;
   logic       o_begin_write, o_begin_transmission, o_read_mem_sel;
   logic       o_load_mem, o_shift_mem, o_busy, o_cmd_error;
   logic [0:0] o_byte_sel;
   logic [5:0] o_enables;

   vector_cmd_ctrl #(
      .NUM_ELEMENTOS(N), .BYTES_PER_RESULT(BPR), .LAT_READ(1), .LAT_SUM(1),
      .LAT_AVG(2), .LAT_TREE(4), .LAT_EUC(20)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_command_ready(i_command_ready),
      .i_command(i_command), .i_write_done(i_write_done), .i_tx_sent(i_tx_sent),
      .o_begin_write(o_begin_write), .o_begin_transmission(o_begin_transmission),
      .o_byte_sel(o_byte_sel), .o_read_mem_sel(o_read_mem_sel), .o_load_mem(o_load_mem),
      .o_shift_mem(o_shift_mem), .o_enables(o_enables), .o_busy(o_busy),
      .o_cmd_error(o_cmd_error)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit       is_write;
      int       lat;
      int       nshift;
      int       nbytes;
      bit [5:0] onehot;
      bit       rms;
   } op_t;

   op_t      op_q[$];
   bit [7:0] tx_q[$];
   int       n_pass = 0;
   int       n_total = 0;
   bit       mon_en = 1'b1;
   bit       slow_tx = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // reference model: derives the whole expected transaction from the command byte
   task automatic push_model(input logic [7:0] c);
      op_t o;
      int  b, elems;
      int  lat_tab[7] = '{0, 1, 1, 2, 20, 4, 4};
      b = 0;
      for (int k = 0; k < 7; k++) if (c[k]) b = k;
      o.is_write = (b == 0);
      o.lat      = lat_tab[b];
      o.onehot   = (b == 0) ? 6'b0 : 6'(1 << (b - 1));
      o.rms      = (b == 1) && !c[7];
      elems      = (b == 0) ? 0 : ((b <= 3) ? N : 1);
      o.nshift   = (elems > 0) ? elems - 1 : 0;
      o.nbytes   = elems * BPR;
      for (int e = 0; e < elems; e++)
         for (int by = 0; by < BPR; by++)
            tx_q.push_back({by[0], o.onehot, o.rms});
      op_q.push_back(o);
   endtask

   // UART model: answers each byte request after a random delay, plus stray pulses elsewhere
   initial begin
      bit pend;
      int cnt;
      pend = 0;
      cnt = 0;
      forever begin
         @(negedge i_clk);
         i_tx_sent = 1'b0;
         if (i_reset) pend = 0;
         else if (pend) begin
            if (cnt == 0) begin i_tx_sent = 1'b1; pend = 0; end
            else cnt--;
         end else if (o_begin_transmission) begin
            pend = 1;
            cnt = slow_tx ? 6 : $urandom_range(0, 3);
         end else if (!slow_tx && $urandom_range(0, 7) == 0) begin
            i_tx_sent = 1'b1;
         end
      end
   end

   // monitor: pops expectations whenever the DUT presents an op or a byte
   initial begin
      op_t cur;
      bit  active, prev_busy, seen_load;
      int  pre_load, nload, nshift, nbytes, nwrite, bad, idle_bad;
      bit [7:0] exp_tx;
      active = 0; prev_busy = 0; seen_load = 0; idle_bad = 0;
      pre_load = 0; nload = 0; nshift = 0; nbytes = 0; nwrite = 0; bad = 0;
      forever begin
         @(negedge i_clk);
         if (mon_en) begin
            if (o_busy && !prev_busy) begin
               active = (op_q.size() != 0);
               if (active) cur = op_q.pop_front();
               else check("unexpected_op", 1, 0);
               pre_load = 0; nload = 0; nshift = 0; nbytes = 0; nwrite = 0; bad = 0; seen_load = 0;
            end
            if (o_busy && active) begin
               if (o_load_mem) begin
                  nload++; seen_load = 1;
                  if (o_byte_sel != 1'b0) bad++;
               end else if (!seen_load) pre_load++;
               if (o_shift_mem) nshift++;
               if (o_begin_write) nwrite++;
               if (o_enables != cur.onehot || o_read_mem_sel != cur.rms) bad++;
               if (o_begin_transmission) begin
                  nbytes++;
                  if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
                  else begin
                     exp_tx = tx_q.pop_front();
                     check("tx_byte_sel_en_rms", {o_byte_sel, o_enables, o_read_mem_sel}, exp_tx);
                  end
               end
            end
            if (!o_busy && (o_begin_write || o_begin_transmission || o_load_mem || o_shift_mem ||
                            o_enables != 0 || o_read_mem_sel || o_byte_sel != 0)) idle_bad++;
            if (!o_busy && prev_busy && active) begin
               if (cur.is_write) check("write_level", nwrite, pre_load);
               else begin
                  check("compute_latency", pre_load, cur.lat);
                  check("write_in_op", nwrite, 0);
               end
               check("load_count", nload, cur.is_write ? 0 : 1);
               check("shift_count", nshift, cur.nshift);
               check("byte_count", nbytes, cur.nbytes);
               check("level_outputs_bad", bad, 0);
               check("cmd_error_clear", o_cmd_error, 0);
               check("idle_outputs_bad", idle_bad, 0);
               active = 0;
            end
         end
         prev_busy = o_busy;
      end
   end

   task automatic run_cmd(input logic [7:0] c);
      int ones, k;
      ones = $countones(c[6:0]);
      k = 0;
      if (ones == 1) push_model(c);
      if ($urandom_range(0, 3) == 0) begin
         @(negedge i_clk); i_write_done = 1'b1;
         @(negedge i_clk); i_write_done = 1'b0;
      end
      @(negedge i_clk);
      i_command = c; i_command_ready = 1'b1;
      @(negedge i_clk);
      i_command_ready = 1'b0;
      if (ones != 1) begin
         check("err_set", o_cmd_error, 1);
         check("err_stays_idle", o_busy, 0);
      end else if (c[0]) begin
         check("write_start", o_begin_write, 1);
         repeat (10) @(negedge i_clk);
         i_write_done = 1'b1;
         @(negedge i_clk);
         i_write_done = 1'b0;
         check("write_end_busy", o_busy, 0);
      end else begin
         while (o_busy && k < 3000) begin
            i_command = 8'($urandom);
            i_command_ready = ($urandom_range(0, 5) == 0);
            @(negedge i_clk);
            i_command_ready = 1'b0;
            k++;
         end
         if (k >= 3000) check("op_timeout", k, 0);
      end
   endtask

   initial begin
      logic [7:0] c;
      int k;
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      check("reset_outputs", {o_begin_write, o_begin_transmission, o_byte_sel, o_read_mem_sel,
                              o_load_mem, o_shift_mem, o_enables, o_busy, o_cmd_error}, 0);

      run_cmd(8'h01);
      run_cmd(8'h04);
      run_cmd(8'h20);
      run_cmd(8'h82);
      run_cmd(8'h02);
      run_cmd(8'h00);
      run_cmd(8'h0C);
      run_cmd(8'h04);
      run_cmd(8'h10);
      run_cmd(8'h48);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       c = {1'($urandom), 7'h01};
            1:       c = {1'($urandom), 7'h00};
            2:       c = {1'($urandom), 7'(7'h03 << $urandom_range(0, 5))};
            default: c = {1'($urandom), 7'(1 << $urandom_range(1, 6))};
         endcase
         run_cmd(c);
      end

      // abort a transfer while waiting for the UART
      mon_en = 1'b0;
      slow_tx = 1'b1;
      @(negedge i_clk);
      i_command = 8'h04; i_command_ready = 1'b1;
      @(negedge i_clk);
      i_command_ready = 1'b0;
      k = 0;
      while (!o_begin_transmission && k < 200) begin @(negedge i_clk); k++; end
      check("abort_reached_send", o_begin_transmission, 1);
      @(negedge i_clk);
      check("abort_busy_before_reset", o_busy, 1);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      check("abort_reset_outputs", {o_begin_write, o_begin_transmission, o_byte_sel, o_read_mem_sel,
                                    o_load_mem, o_shift_mem, o_enables, o_busy, o_cmd_error}, 0);
      op_q.delete();
      tx_q.delete();
      repeat (10) @(negedge i_clk);
      slow_tx = 1'b0;
      mon_en = 1'b1;
      run_cmd(8'h40);

      repeat (5) @(negedge i_clk);
      check("op_queue_drained", op_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vector_cmd_ctrl.md
Name: vector_cmd_ctrl

Overview:
Parametrised command/control FSM for the vector coprocessor. Sits between the UART command decoder and the datapath: the two vector BRAMs, the op units (READ/SUM/AVG/EUC/MAN/DOT) and the result PISO feeding the UART TX.
- Implements all six ops, with a per-op latency.
- Sends results as multi-byte elements.
- Distinguishes vector results from scalar results.
- Flags malformed commands.

Parameters:
NUM_ELEMENTOS, 1024, vector length (elements per vector result)
BYTES_PER_RESULT, 2, bytes transmitted per result element, MSB first (>=1)
LAT_READ, 1, COMPUTE cycles for READ
LAT_SUM, 1, COMPUTE cycles for SUM
LAT_AVG, 2, COMPUTE cycles for AVG
LAT_TREE, $clog2(NUM_ELEMENTOS)+2, COMPUTE cycles for MAN and DOT (adder tree)
LAT_EUC, $clog2(NUM_ELEMENTOS)+18, COMPUTE cycles for EUC (tree + sqrt)

Ports:
clk  in  1  100 MHz clock
reset  in  1  synchronous, active-high
command_ready  in  1  one-cycle pulse, command valid
command  in  8  bit0 WRITE, 1 READ, 2 SUM, 3 AVG, 4 EUC, 5 MAN, 6 DOT, 7 memory select (0=A, 1=B)
write_done  in  1  write engine finished
tx_sent  in  1  one-cycle pulse, UART byte transmitted
begin_write  out  1  level, write engine run
begin_transmission  out  1  one-cycle pulse per byte
byte_sel  out  max(1,$clog2(BYTES_PER_RESULT))  byte of current element to drive onto TX
read_mem_sel  out  1  memory read by READ
load_mem  out  1  parallel-load result PISO
shift_mem  out  1  advance result PISO one element
enables  out  6  op enables: [0]READ [1]SUM [2]AVG [3]EUC [4]MAN [5]DOT
busy  out  1  high whenever state != IDLE
cmd_error  out  1  sticky malformed-command flag

Behaviour:
- Reset: state IDLE. All outputs 0. Internal timer, byte_sel, element counter and latched op cleared. Applies the same mid-operation: next cycle is IDLE with every output 0.
- States: IDLE, WRITE, COMPUTE, STORE, SEND, WAIT_TX, SHIFT.
- IDLE handling of command_ready:
  - Count set bits in command[6:0].
  - Exactly one bit set: latch command, clear cmd_error. bit0 goes to WRITE, any other bit goes to COMPUTE.
  - Zero or more than one bit set: set cmd_error, stay in IDLE.
- command_ready outside IDLE is ignored; no queuing.
- WRITE:
  - begin_write=1.
  - write_done=1 gives IDLE next cycle.
  - write_done outside WRITE is ignored.
- COMPUTE:
  - Timer t starts at 0 on entry.
  - Exit to STORE when t == LAT_op-1, so COMPUTE lasts exactly LAT_op cycles.
- STORE: exactly one cycle with load_mem=1, then SEND.
- SEND: exactly one cycle with begin_transmission=1, then WAIT_TX.
- WAIT_TX: hold until tx_sent. On tx_sent:
  - If byte_sel < BYTES_PER_RESULT-1: byte_sel+1, go to SEND.
  - Else, vector op (READ/SUM/AVG) with element count < NUM_ELEMENTOS-1: go to SHIFT.
  - Else: go to IDLE.
- SHIFT: one cycle with shift_mem=1. Element count +1, byte_sel=0, then SEND.
- Scalar ops (EUC/MAN/DOT) send exactly one element: BYTES_PER_RESULT bytes, no SHIFT.
- Vector ops send NUM_ELEMENTOS×BYTES_PER_RESULT bytes with NUM_ELEMENTOS-1 SHIFT pulses.
- tx_sent outside WAIT_TX is ignored. begin_transmission is never asserted twice without an intervening tx_sent.
- enables: bit of the latched op is held high from COMPUTE through the last WAIT_TX; 0 in IDLE and WRITE.
- read_mem_sel = ~command[7] (latched); driven only while op=READ and state != IDLE, else 0.
- byte_sel is 0 in IDLE and on entry to STORE.
- Element counter width $clog2(NUM_ELEMENTOS)+1; must not wrap at any legal NUM_ELEMENTOS.

Test Plan:
Bench parameters: NUM_ELEMENTOS=4, BYTES_PER_RESULT=2, LAT_SUM=1, LAT_TREE=4.
- Reset then command=0x01 → begin_write high next cycle. write_done after 10 cycles → IDLE, busy=0 one cycle later.
- command=0x04 (SUM), tx_sent returned 3 cycles after each pulse → COMPUTE 1 cycle, one load_mem, 8 begin_transmission pulses with byte_sel 0,1,0,1,… and 3 shift_mem pulses; enables=6'b000010 throughout; then IDLE.
- command=0x20 (MAN) → COMPUTE exactly 4 cycles, 2 byte pulses, zero shift_mem, enables=6'b010000, then IDLE.
- command=0x82 (READ, B) → read_mem_sel=0 during the op. command=0x02 → read_mem_sel=1.
- command=0x00 and 0x0C → cmd_error=1, stays IDLE. Then 0x04 → cmd_error=0.
- Extra tx_sent during COMPUTE, command_ready during SEND, reset asserted during WAIT_TX → no state change from the strays; reset gives IDLE with all outputs 0 next cycle.
